// File: rtl/input_debouncer.sv
// Per-channel two-flop synchronizer, debounce counter and registered level/rise/fall outputs.
// Define INPUT_DEBOUNCER_AUTOREPEAT_EN to add auto-repeat rise strobes on channel 0.
module input_debouncer #(
    parameter int CH            = 3,
    parameter int DB_CYCLES     = 8,
    parameter int REPEAT_DELAY  = 64,
    parameter int REPEAT_PERIOD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic [CH-1:0] raw_in,
    output logic [CH-1:0] level,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall
);

    localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

    logic [CH-1:0] s1_q, s1_d;
    logic [CH-1:0] s2_q, s2_d;
    logic [7:0]    cnt_q [CH];
    logic [7:0]    cnt_d [CH];
    logic [CH-1:0] level_q, level_d;
    logic [CH-1:0] rise_q, rise_d;
    logic [CH-1:0] fall_q, fall_d;
    logic [CH-1:0] accept;
    logic [CH-1:0] rep_rise;

    // A channel accepts a new level only after DB_CYCLES consecutive enabled mismatches.
    always_comb begin
        s1_d    = raw_in;
        s2_d    = s1_q;
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        accept  = '0;
        for (int c = 0; c < CH; c++) begin
            cnt_d[c] = cnt_q[c];
            if (!ena || (s2_q[c] == level_q[c])) begin
                cnt_d[c] = '0;
            end else if (cnt_q[c] == DB_LAST) begin
                accept[c]  = 1'b1;
                level_d[c] = s2_q[c];
                rise_d[c]  = s2_q[c];
                fall_d[c]  = ~s2_q[c];
                cnt_d[c]   = '0;
            end else begin
                cnt_d[c] = cnt_q[c] + 8'd1;
            end
        end
    end

`ifdef INPUT_DEBOUNCER_AUTOREPEAT_EN
    localparam logic [15:0] REP_DELAY_LAST  = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] REP_PERIOD_LAST = 16'(REPEAT_PERIOD - 1);

    logic [15:0] rep_cnt_q, rep_cnt_d;
    logic        rep_phase_q, rep_phase_d;
    logic        rep_fire;

    // Restarting on any accept makes the accepted press edge the reference point E.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_phase_d = rep_phase_q;
        rep_fire    = 1'b0;
        if (!ena || accept[0] || !level_q[0]) begin
            rep_cnt_d   = '0;
            rep_phase_d = 1'b0;
        end else if (!rep_phase_q && (rep_cnt_q == REP_DELAY_LAST)) begin
            rep_fire    = 1'b1;
            rep_cnt_d   = '0;
            rep_phase_d = 1'b1;
        end else if (rep_phase_q && (rep_cnt_q == REP_PERIOD_LAST)) begin
            rep_fire  = 1'b1;
            rep_cnt_d = '0;
        end else begin
            rep_cnt_d = rep_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
        end
    end

    assign rep_rise = CH'(rep_fire);
`else
    assign rep_rise = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int c = 0; c < CH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            level_q <= level_d;
            rise_q  <= rise_d | rep_rise;
            fall_q  <= fall_d;
            for (int c = 0; c < CH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer: directed scenarios plus randomized bouncing inputs
// compared every cycle against a sliding-window behavioural model.
module tb_input_debouncer;

    localparam int CH = 3;
    localparam int DB = 8;
    localparam int RD = 64;
    localparam int RP = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic [CH-1:0] raw_in;
    logic [CH-1:0] level;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    input_debouncer #(
        .CH           (CH),
        .DB_CYCLES    (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .raw_in(raw_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    // Model state: a level is accepted once the last DB synchronized samples all
    // disagree with it while enabled; auto-repeat is measured as edges since the press.
    logic [CH-1:0] m_level, m_rise, m_fall, m_s1, m_s2;
    logic [CH-1:0] h_s2 [DB];
    bit            h_ena [DB];
    int            age;

    task automatic check_output(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_s1    = '0;
        m_s2    = '0;
        age     = 0;
        for (int i = 0; i < DB; i++) begin
            h_s2[i]  = '0;
            h_ena[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit acc;
        bit prev_l0;
        bit fall0;
        bit press0;
        for (int i = DB - 1; i > 0; i--) begin
            h_s2[i]  = h_s2[i-1];
            h_ena[i] = h_ena[i-1];
        end
        h_s2[0]  = m_s2;
        h_ena[0] = ena;
        prev_l0  = m_level[0];
        m_rise   = '0;
        m_fall   = '0;
        for (int c = 0; c < CH; c++) begin
            acc = 1'b1;
            for (int i = 0; i < DB; i++) begin
                if (!h_ena[i] || (h_s2[i][c] == m_level[c])) acc = 1'b0;
            end
            if (acc) begin
                m_level[c] = ~m_level[c];
                if (m_level[c]) m_rise[c] = 1'b1;
                else            m_fall[c] = 1'b1;
            end
        end
        press0 = m_rise[0];
        fall0  = m_fall[0];
`ifdef INPUT_DEBOUNCER_AUTOREPEAT_EN
        if (press0 || fall0 || !ena || !prev_l0) begin
            age = 0;
        end else begin
            age++;
            if ((age == RD) || ((age > RD) && (((age - RD) % RP) == 0))) m_rise[0] = 1'b1;
        end
`else
        if (press0 || fall0 || !prev_l0) age = 0;
`endif
        m_s2 = m_s1;
        m_s1 = raw_in;
    endtask

    // Single compare process: the model advances on each edge and the DUT is checked 1ns later.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
            #1;
            check_output("model_level", int'(level), int'(m_level));
            check_output("model_rise",  int'(rise),  int'(m_rise));
            check_output("model_fall",  int'(fall),  int'(m_fall));
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int cycles);
        int  hold [CH];
        bit  bouncy [CH];
        int  ena_hold;
        ena_hold = 0;
        for (int c = 0; c < CH; c++) begin
            hold[c]   = 0;
            bouncy[c] = 1'b0;
        end
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                if (hold[c] == 0) begin
                    bouncy[c] = ($urandom_range(0, 2) == 0);
                    hold[c]   = $urandom_range(1, 200);
                    if (!bouncy[c]) raw_in[c] = 1'($urandom_range(0, 1));
                end
                hold[c]--;
                if (bouncy[c] && ($urandom_range(0, 2) == 0)) raw_in[c] = ~raw_in[c];
            end
            if (ena_hold == 0) begin
                ena      = ($urandom_range(0, 9) != 0);
                ena_hold = ena ? $urandom_range(20, 300) : $urandom_range(1, 20);
            end
            ena_hold--;
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        int rises;
        bit seen_fall;
        int bad_rise;

        rst_n  = 1'b0;
        ena    = 1'b1;
        raw_in = 3'b111;
        repeat (5) @(negedge clk);
        check_output("reset_level", int'(level), 0);
        check_output("reset_rise",  int'(rise),  0);
        check_output("reset_fall",  int'(fall),  0);
        raw_in = '0;
        rst_n  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wait_edges(1);
            check_output("post_reset_out", int'({level, rise, fall}), 0);
        end

        // Clean press on channel 0: edges 0..8 quiet, edge 9 accepts.
        @(negedge clk);
        raw_in[0] = 1'b1;
        wait_edges(9);
        check_output("press_level_e8", int'(level), 0);
        check_output("press_rise_e8",  int'(rise),  0);
        wait_edges(1);
        check_output("press_level_e9", int'(level), 1);
        check_output("press_rise_e9",  int'(rise),  1);
        wait_edges(1);
        check_output("press_rise_e10", int'(rise[0]), 0);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            raw_in[1] = (i < 5);
            wait_edges(1);
            check_output("glitch_ch1", int'({level[1], rise[1], fall[1]}), 0);
        end

        @(negedge clk);
        raw_in[0] = 1'b0;
        wait_edges(9);
        check_output("release_fall_e8",  int'(fall[0]),  0);
        check_output("release_level_e8", int'(level[0]), 1);
        wait_edges(1);
        check_output("release_fall_e9",  int'(fall[0]),  1);
        check_output("release_level_e9", int'(level[0]), 0);
        wait_edges(1);
        check_output("release_fall_e10", int'(fall[0]), 0);

        @(negedge clk);
        ena       = 1'b0;
        raw_in[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wait_edges(1);
            check_output("gated_level_rise", int'({level[0], rise[0]}), 0);
        end
        @(negedge clk);
        ena   = 1'b1;
        rises = 0;
        for (int i = 0; i < 9; i++) begin
            wait_edges(1);
            rises += int'(rise[0]);
        end
        check_output("ena_level", int'(level[0]), 1);
        check_output("ena_rises", rises, 1);

        @(negedge clk);
        raw_in[0] = 1'b0;
        wait_edges(12);
        check_output("ena_release_level", int'(level[0]), 0);

        // Reset pulse mid-debounce discards progress; full latency restarts afterwards.
        @(negedge clk);
        raw_in[0] = 1'b1;
        wait_edges(5);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rises = 0;
        for (int i = 0; i < 9; i++) begin
            wait_edges(1);
            rises += int'(rise[0]);
        end
        check_output("rst_mid_rises",  rises, 0);
        check_output("rst_mid_level8", int'(level[0]), 0);
        wait_edges(1);
        check_output("rst_mid_level9", int'(level[0]), 1);
        check_output("rst_mid_rise9",  int'(rise[0]),  1);

        bad_rise = 0;
        for (int k = 1; k <= 100; k++) begin
            wait_edges(1);
`ifdef INPUT_DEBOUNCER_AUTOREPEAT_EN
            if (rise[0] !== ((k == RD) || (k == RD + RP) || (k == RD + 2 * RP))) bad_rise++;
`else
            if (rise[0] !== 1'b0) bad_rise++;
`endif
        end
        check_output("repeat_pattern", bad_rise, 0);
        @(negedge clk);
        raw_in[0] = 1'b0;
        seen_fall = 1'b0;
        rises     = 0;
        for (int i = 0; i < 20; i++) begin
            wait_edges(1);
            if (fall[0]) seen_fall = 1'b1;
            if (seen_fall) rises += int'(rise[0]);
        end
        check_output("repeat_release_fall", int'(seen_fall), 1);
        check_output("repeat_after_fall",   rises, 0);

        apply_stimulus(5000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
